// File: rtl/uart_rx_cmd_ctrl.sv
// uart_rx_cmd_ctrl: turns the UART receiver's valid level into byte strobes,
// sequences 4-byte write frames (sync, address, data, checksum) into single
// register-bank writes, enforces an inter-byte timeout and counts errors.
module uart_rx_cmd_ctrl #(
    parameter int clk_mhz      = 50,
    parameter int boadrate     = 9600,
    parameter int timeout_bits = 40
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       wr_en,
    output logic [3:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [7:0] err_count,
    output logic       busy
);

    localparam logic [31:0] TIMEOUT_CYCLES = 32'(clk_mhz * 1_000_000 / boadrate * timeout_bits);
    localparam logic [7:0]  SYNC_BYTE      = 8'hA5;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        CHK
    } state_t;

    state_t      state_q, state_d;
    logic        rx_valid_q, rx_valid_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic [31:0] cnt_q, cnt_d;
    logic        wr_en_q, wr_en_d;
    logic [3:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        frame_ok_q, frame_ok_d;
    logic        frame_err_q, frame_err_d;
    logic [7:0]  err_count_q, err_count_d;
    logic        stb;
    logic        frame_good;

    // A new byte is the rising edge of the receiver's valid level; the
    // registered copy resets high so a level held through reset is not a byte.
    assign stb        = rx_valid & ~rx_valid_q;
    assign rx_valid_d = rx_valid;

    // The checksum byte on rx_data is compared against the latched address/data;
    // only the lower 16 addresses exist in the register bank.
    assign frame_good = (rx_data == (SYNC_BYTE ^ addr_q ^ data_q)) && (addr_q[7:4] == 4'h0);

    // Frame sequencing, timeout countdown and error bookkeeping.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        data_d      = data_q;
        cnt_d       = cnt_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        err_count_d = err_count_q;

        if (state_q == IDLE) begin
            cnt_d = TIMEOUT_CYCLES;
            if (stb && (rx_data == SYNC_BYTE)) begin
                state_d = ADDR;
            end
        end else if (stb) begin
            cnt_d = TIMEOUT_CYCLES;
            case (state_q)
                ADDR: begin
                    addr_d  = rx_data;
                    state_d = DATA;
                end
                DATA: begin
                    data_d  = rx_data;
                    state_d = CHK;
                end
                CHK: begin
                    state_d = IDLE;
                    if (frame_good) begin
                        wr_en_d    = 1'b1;
                        frame_ok_d = 1'b1;
                        wr_addr_d  = addr_q[3:0];
                        wr_data_d  = data_q;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (cnt_q == 32'd0) begin
            frame_err_d = 1'b1;
            state_d     = IDLE;
        end else begin
            cnt_d = cnt_q - 32'd1;
        end

        if (frame_err_d && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    // State and output registers; reset aborts any frame in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rx_valid_q  <= 1'b1;
            addr_q      <= 8'h00;
            data_q      <= 8'h00;
            cnt_q       <= TIMEOUT_CYCLES;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= 4'h0;
            wr_data_q   <= 8'h00;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_count_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            rx_valid_q  <= rx_valid_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            err_count_q <= err_count_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign err_count = err_count_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_cmd_ctrl.sv
// Testbench for uart_rx_cmd_ctrl: directed frames from the test plan plus
// randomized traffic, every cycle compared against a frame-level model.
module tb_uart_rx_cmd_ctrl;

    localparam int CLK_MHZ  = 1;
    localparam int BAUD     = 100000;
    localparam int TO_BITS  = 40;
    localparam int TIMEOUT  = CLK_MHZ * 1_000_000 / BAUD * TO_BITS;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       frame_ok;
    logic       frame_err;
    logic [7:0] err_count;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // Pulses observed on the DUT, used for per-scenario delta checks.
    int nWr  = 0;
    int nOk  = 0;
    int nErr = 0;

    // Reference model: bytes of the frame collected so far, absolute cycle
    // number of the last accepted byte, and the expected visible outputs.
    byte unsigned frameBytes[$];
    int unsigned  cycleNum = 0;
    int unsigned  lastByteCycle = 0;
    bit           prevValid = 1'b1;
    bit           mWrEn, mOk, mErr;
    bit [3:0]     mAddr;
    bit [7:0]     mData;
    int           mErrCount;

    uart_rx_cmd_ctrl #(
        .clk_mhz     (CLK_MHZ),
        .boadrate    (BAUD),
        .timeout_bits(TO_BITS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .frame_ok (frame_ok),
        .frame_err(frame_err),
        .err_count(err_count),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s (cycle %0d): got %0h expected %0h", tag, cycleNum, act, exp);
        end
    endtask

    task automatic modelReset();
        frameBytes.delete();
        prevValid = 1'b1;
        mWrEn = 0; mOk = 0; mErr = 0;
        mAddr = 4'h0; mData = 8'h00;
        mErrCount = 0;
    endtask

    // One clock edge of the frame-level model, using the inputs the DUT sampled.
    task automatic modelEdge();
        bit strobe;
        bit [7:0] sum;
        cycleNum++;
        mWrEn = 0; mOk = 0; mErr = 0;
        if (rst) begin
            modelReset();
            return;
        end
        strobe    = rx_valid && !prevValid;
        prevValid = rx_valid;
        if (frameBytes.size() == 0) begin
            if (strobe && rx_data == 8'hA5) begin
                frameBytes.push_back(rx_data);
                lastByteCycle = cycleNum;
            end
        end else if (strobe) begin
            frameBytes.push_back(rx_data);
            lastByteCycle = cycleNum;
            if (frameBytes.size() == 4) begin
                sum = frameBytes[0] ^ frameBytes[1] ^ frameBytes[2];
                if (frameBytes[3] == sum && frameBytes[1] < 16) begin
                    mWrEn = 1; mOk = 1;
                    mAddr = frameBytes[1][3:0];
                    mData = frameBytes[2];
                end else begin
                    mErr = 1;
                end
                frameBytes.delete();
            end
        end else if (cycleNum - lastByteCycle == TIMEOUT + 1) begin
            mErr = 1;
            frameBytes.delete();
        end
        if (mErr && mErrCount < 255) mErrCount++;
    endtask

    task automatic compareAll();
        if (wr_en)     nWr++;
        if (frame_ok)  nOk++;
        if (frame_err) nErr++;
        checkOutput("wr_en",     32'(wr_en),     32'(mWrEn));
        checkOutput("wr_addr",   32'(wr_addr),   32'(mAddr));
        checkOutput("wr_data",   32'(wr_data),   32'(mData));
        checkOutput("frame_ok",  32'(frame_ok),  32'(mOk));
        checkOutput("frame_err", 32'(frame_err), 32'(mErr));
        checkOutput("err_count", 32'(err_count), 32'(mErrCount));
        checkOutput("busy",      32'(busy),      32'(frameBytes.size() != 0));
    endtask

    task automatic tick();
        @(posedge clk);
        modelEdge();
        #1;
        compareAll();
    endtask

    // Drive one byte as a valid pulse: hi cycles high, lo cycles low.
    task automatic applyStimulus(input logic [7:0] b, input int hi, input int lo);
        rx_data  = b;
        rx_valid = 1'b1;
        repeat (hi) tick();
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        repeat (lo) tick();
    endtask

    task automatic sendFrame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
        applyStimulus(8'hA5, 3, 5);
        applyStimulus(a, 3, 5);
        applyStimulus(d, 3, 5);
        applyStimulus(c, 3, 5);
    endtask

    initial begin
        int wr0, ok0, err0, ec0;
        modelReset();
        repeat (3) tick();
        rst = 1'b0;
        tick();
        checkOutput("reset_err_count", 32'(err_count), 0);
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_wr_addr", 32'(wr_addr), 0);

        // Good frame
        wr0 = nWr; ok0 = nOk; err0 = nErr;
        sendFrame(8'h03, 8'h5C, 8'hFA);
        checkOutput("good_wr_count", 32'(nWr - wr0), 1);
        checkOutput("good_ok_count", 32'(nOk - ok0), 1);
        checkOutput("good_err_count", 32'(nErr - err0), 0);
        checkOutput("good_wr_addr", 32'(wr_addr), 32'h3);
        checkOutput("good_wr_data", 32'(wr_data), 32'h5C);
        checkOutput("good_busy", 32'(busy), 0);

        // Bad checksum, then bad address
        wr0 = nWr;
        sendFrame(8'h03, 8'h5C, 8'h00);
        checkOutput("badchk_err_count", 32'(err_count), 1);
        sendFrame(8'h13, 8'h5C, 8'hEA);
        checkOutput("badaddr_err_count", 32'(err_count), 2);
        checkOutput("bad_wr_count", 32'(nWr - wr0), 0);

        // Noise before sync
        wr0 = nWr;
        applyStimulus(8'h11, 3, 5);
        applyStimulus(8'h22, 3, 5);
        checkOutput("noise_busy", 32'(busy), 0);
        sendFrame(8'h0F, 8'h01, 8'hAB);
        checkOutput("noise_wr_count", 32'(nWr - wr0), 1);
        checkOutput("noise_wr_addr", 32'(wr_addr), 32'hF);
        checkOutput("noise_wr_data", 32'(wr_data), 32'h01);

        // Timeout: last byte strobed at E0, silence through E400, error at E401
        err0 = nErr; ec0 = int'(err_count);
        applyStimulus(8'hA5, 3, 5);
        applyStimulus(8'h02, 3, 5);
        repeat (TIMEOUT - 7) tick();
        checkOutput("to_no_err_yet", 32'(nErr - err0), 0);
        checkOutput("to_busy_before", 32'(busy), 1);
        tick();
        checkOutput("to_frame_err", 32'(frame_err), 1);
        checkOutput("to_busy_after", 32'(busy), 0);
        checkOutput("to_err_count", 32'(err_count), 32'(ec0 + 1));

        // Strobe on the expiry cycle wins and the frame continues
        err0 = nErr; wr0 = nWr;
        applyStimulus(8'hA5, 3, 5);
        applyStimulus(8'h02, 3, 5);
        repeat (TIMEOUT - 7) tick();
        applyStimulus(8'h5A, 3, 5);
        checkOutput("exp_no_err", 32'(nErr - err0), 0);
        checkOutput("exp_busy", 32'(busy), 1);
        applyStimulus(8'hFD, 3, 5);
        checkOutput("exp_wr_count", 32'(nWr - wr0), 1);
        checkOutput("exp_wr_data", 32'(wr_data), 32'h5A);

        // Asynchronous reset mid-frame
        applyStimulus(8'hA5, 3, 5);
        applyStimulus(8'h04, 3, 5);
        #3 rst = 1'b1;
        #1 modelReset();
        compareAll();
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_err_count", 32'(err_count), 0);
        checkOutput("rst_wr_data", 32'(wr_data), 0);
        repeat (2) tick();
        rx_data = 8'hA5; rx_valid = 1'b1;
        tick();
        rst = 1'b0;
        repeat (4) tick();
        checkOutput("rst_no_strobe", 32'(busy), 0);
        rx_valid = 1'b0;
        tick();

        // Randomized traffic
        for (int f = 0; f < 80; f++) begin
            int kind;
            logic [7:0] a, d, c;
            kind = $urandom_range(0, 5);
            a = 8'($urandom_range(0, 15));
            d = 8'($urandom);
            c = 8'hA5 ^ a ^ d;
            if (kind == 4) c = c ^ 8'($urandom_range(1, 255));
            if (kind == 5) a = a | 8'($urandom_range(1, 15) << 4);
            if (kind == 5) c = 8'hA5 ^ a ^ d;
            if (kind == 0) begin
                applyStimulus(8'($urandom), $urandom_range(1, 4), $urandom_range(1, 6));
            end else begin
                applyStimulus(8'hA5, $urandom_range(1, 4), $urandom_range(1, 6));
                applyStimulus(a, $urandom_range(1, 4), $urandom_range(1, 6));
                if ($urandom_range(0, 7) == 0) repeat ($urandom_range(TIMEOUT - 8, TIMEOUT + 4)) tick();
                applyStimulus(d, $urandom_range(1, 4), $urandom_range(1, 6));
                applyStimulus(c, $urandom_range(1, 4), $urandom_range(1, 6));
            end
        end

        // Saturation of the error counter
        repeat (20) tick();
        for (int f = 0; f < 260; f++) begin
            sendFrame(8'h00, 8'h00, 8'h00);
            if (f == 255) checkOutput("sat_at_256", 32'(err_count), 255);
        end
        checkOutput("sat_final", 32'(err_count), 255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
